// File: rtl/ball_motion_ctrl_pkg.sv
// game_pkg: shared definitions for the Breakout ball/paddle sequencer.
//   - game_state_t : FSM encoding, which is also the game_state output encoding
//   - dir_t        : per-axis ball direction
//   - screen geometry, motion constants and the derived playfield limits
package game_pkg;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_MISS  = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    localparam int SCREEN_W     = 1440;
    localparam int SCREEN_H     = 900;
    localparam int BORDER       = 10;
    localparam int BALL_SIZE    = 24;
    localparam int PADDLE_W     = 120;
    localparam int PADDLE_Y     = 850;
    localparam int BALL_SPEED   = 4;
    localparam int PADDLE_SPEED = 8;
    localparam int MISS_FRAMES  = 60;
    localparam int START_LIVES  = 3;

    // Playfield limits
    localparam int X_MIN  = BORDER;
    localparam int BX_MAX = SCREEN_W - BORDER - BALL_SIZE - 1;
    localparam int Y_MIN  = BORDER + 1;
    localparam int PX_MAX = SCREEN_W - BORDER - PADDLE_W - 1;
    localparam int MISS_Y = SCREEN_H - BORDER - BALL_SIZE;

    // Serve geometry: ball centred on the paddle, resting one row above it
    localparam int PADDLE_X_RST = (SCREEN_W - PADDLE_W) / 2;
    localparam int BALL_X_OFS   = (PADDLE_W - BALL_SIZE) / 2;
    localparam int BALL_X_RST   = PADDLE_X_RST + BALL_X_OFS;
    localparam int BALL_Y_SERVE = PADDLE_Y - BALL_SIZE - 1;

endpackage

// File: rtl/ball_motion_ctrl_paddle_mover.sv
// paddle_mover: paddle horizontal position register.
//   clk, rst       : clock, asynchronous active-high reset
//   en             : advance one step this cycle (frame tick while not game over)
//   btn_left/right : debounced direction levels; both or neither means no move
//   paddle_x       : registered paddle left column
//   paddle_x_next  : value paddle_x takes at the next edge (lets the ball track it in SERVE)
module paddle_mover
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [10:0] paddle_x,
    output logic [10:0] paddle_x_next
);

    localparam logic signed [11:0] STEP   = 12'(PADDLE_SPEED);
    localparam logic signed [11:0] SX_MIN = 12'(X_MIN);
    localparam logic signed [11:0] SX_MAX = 12'(PX_MAX);

    // Saturate a signed candidate position onto the legal paddle range
    function automatic logic [10:0] clamp_paddle(input logic signed [11:0] v);
        if (v < SX_MIN)
            return 11'(X_MIN);
        else if (v > SX_MAX)
            return 11'(PX_MAX);
        else
            return v[10:0];
    endfunction

    logic signed [11:0] pos;

    always_comb begin
        pos           = $signed({1'b0, paddle_x}) + (btn_left ? -STEP : STEP);
        paddle_x_next = paddle_x;
        if (en && (btn_left ^ btn_right))
            paddle_x_next = clamp_paddle(pos);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            paddle_x <= 11'(PADDLE_X_RST);
        else
            paddle_x <= paddle_x_next;
    end

endmodule

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: per-frame Breakout sequencer (serve/play/miss/over).
//   clk, rst     : clock, asynchronous active-high reset
//   frame_tick   : one-cycle pulse per frame; all game state advances only on it
//   btn_left/right/launch : debounced button levels
//   paddle_x/y   : paddle left column / fixed top row
//   ball_x/y     : ball left column / top row
//   lives        : remaining lives
//   game_state   : 0 SERVE, 1 PLAY, 2 MISS, 3 OVER
//   miss_pulse   : one-cycle pulse when the ball passes the paddle
module ball_motion_ctrl
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_launch,
    output logic [10:0] paddle_x,
    output logic [9:0]  paddle_y,
    output logic [10:0] ball_x,
    output logic [9:0]  ball_y,
    output logic [1:0]  lives,
    output logic [1:0]  game_state,
    output logic        miss_pulse
);

    localparam logic signed [11:0] BSTEP    = 12'(BALL_SPEED);
    localparam logic signed [11:0] SX_MIN   = 12'(X_MIN);
    localparam logic signed [11:0] SBX_MAX  = 12'(BX_MAX);
    localparam logic signed [11:0] SY_MIN   = 12'(Y_MIN);
    localparam logic signed [11:0] SMISS_Y  = 12'(MISS_Y);
    localparam logic signed [11:0] SBALL    = 12'(BALL_SIZE);
    localparam logic signed [11:0] SPAD_Y   = 12'(PADDLE_Y);
    localparam logic signed [11:0] SPAD_W   = 12'(PADDLE_W);

    game_state_t        state;
    dir_t               dx, dy;
    logic [5:0]         miss_cnt;
    logic [10:0]        paddle_x_next;

    logic signed [11:0] bx_s, by_s, px_s, nx, ny;
    logic               hit, miss;
    logic [10:0]        x_play;
    logic [9:0]         y_play;
    dir_t               dx_play, dy_play;
    logic [1:0]         lives_dec;

    assign paddle_y   = 10'(PADDLE_Y);
    assign game_state = state;

    paddle_mover u_paddle (
        .clk           (clk),
        .rst           (rst),
        .en            (frame_tick && (state != ST_OVER)),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .paddle_x      (paddle_x),
        .paddle_x_next (paddle_x_next)
    );

    // Candidate ball step for PLAY; wall clamps and paddle bounce resolved here.
    // X and Y are resolved independently so a corner reflects both axes at once.
    always_comb begin
        bx_s = $signed({1'b0, ball_x});
        by_s = $signed({2'b00, ball_y});
        px_s = $signed({1'b0, paddle_x});
        nx   = bx_s + ((dx == DIR_POS) ? BSTEP : -BSTEP);
        ny   = by_s + ((dy == DIR_POS) ? BSTEP : -BSTEP);

        // Paddle contact uses the pre-move ball and the pre-move paddle
        hit = (dy == DIR_POS) && (ny + SBALL >= SPAD_Y) && (by_s + SBALL < SPAD_Y) &&
              (bx_s + SBALL >= px_s) && (bx_s <= px_s + SPAD_W);

        x_play  = nx[10:0];
        dx_play = dx;
        if (nx < SX_MIN) begin
            x_play  = 11'(X_MIN);
            dx_play = DIR_POS;
        end else if (nx > SBX_MAX) begin
            x_play  = 11'(BX_MAX);
            dx_play = DIR_NEG;
        end

        y_play  = ny[9:0];
        dy_play = dy;
        miss    = 1'b0;
        if (ny < SY_MIN) begin
            y_play  = 10'(Y_MIN);
            dy_play = DIR_POS;
        end else if (hit) begin
            y_play  = 10'(BALL_Y_SERVE);
            dy_play = DIR_NEG;
        end else if (ny >= SMISS_Y) begin
            miss = 1'b1;
        end

        lives_dec = (lives != 2'd0) ? lives - 2'd1 : lives;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_SERVE;
            ball_x     <= 11'(BALL_X_RST);
            ball_y     <= 10'(BALL_Y_SERVE);
            dx         <= DIR_POS;
            dy         <= DIR_NEG;
            lives      <= 2'(START_LIVES);
            miss_cnt   <= 6'd0;
            miss_pulse <= 1'b0;
        end else begin
            // Pulse lasts exactly one clock, independent of the frame rate
            miss_pulse <= 1'b0;
            if (frame_tick) begin
                case (state)
                    ST_SERVE: begin
                        ball_x <= paddle_x_next + 11'(BALL_X_OFS);
                        ball_y <= 10'(BALL_Y_SERVE);
                        if (btn_launch) begin
                            state <= ST_PLAY;
                            dx    <= DIR_POS;
                            dy    <= DIR_NEG;
                        end
                    end
                    ST_PLAY: begin
                        ball_x <= x_play;
                        ball_y <= y_play;
                        dx     <= dx_play;
                        dy     <= dy_play;
                        if (miss) begin
                            lives      <= lives_dec;
                            miss_pulse <= 1'b1;
                            miss_cnt   <= 6'd0;
                            state      <= (lives_dec != 2'd0) ? ST_MISS : ST_OVER;
                        end
                    end
                    ST_MISS: begin
                        if (miss_cnt == 6'(MISS_FRAMES - 1))
                            state <= ST_SERVE;
                        else
                            miss_cnt <= miss_cnt + 6'd1;
                    end
                    ST_OVER: begin
                        if (btn_launch) begin
                            lives <= 2'(START_LIVES);
                            state <= ST_SERVE;
                        end
                    end
                    default: state <= ST_SERVE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: a table of SERVE-phase paddle moves,
// then hand-traced ball trajectories covering wall clamps, a combined wall +
// paddle reflection, a paddle miss, the MISS hold time and game over/restart.
module tb_ball_motion_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_launch = 1'b0;
    logic [10:0] paddle_x;
    logic [9:0]  paddle_y;
    logic [10:0] ball_x;
    logic [9:0]  ball_y;
    logic [1:0]  lives;
    logic [1:0]  game_state;
    logic        miss_pulse;

    int total = 0;
    int bad   = 0;

    ball_motion_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_launch (btn_launch),
        .paddle_x   (paddle_x),
        .paddle_y   (paddle_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .lives      (lives),
        .game_state (game_state),
        .miss_pulse (miss_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic left;
        logic right;
        int   n;
        int   exp_px;
        int   exp_bx;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_ball(input string name, input int bx, input int by, input int st);
        check({name, "_bx"}, int'(ball_x), bx);
        check({name, "_by"}, int'(ball_y), by);
        check({name, "_st"}, int'(game_state), st);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_px"}, int'(paddle_x), 660);
        check({name, "_py"}, int'(paddle_y), 850);
        check_ball(name, 708, 825, 0);
        check({name, "_lives"}, int'(lives), 3);
        check({name, "_miss"}, int'(miss_pulse), 0);
    endtask

    // n frame ticks with the given button levels; returns at the negedge
    // just after the last tick has been registered
    task automatic ticks(input int n, input logic l, input logic r, input logic la);
        btn_left   = l;
        btn_right  = r;
        btn_launch = la;
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst        = 1'b1;
        frame_tick = 1'b1;
        btn_launch = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        frame_tick = 1'b0;
        btn_launch = 1'b0;
        @(negedge clk);
    endtask

    task automatic miss_hold(input string name, input logic la);
        ticks(59, 1'b0, 1'b0, la);
        check({name, "_59_st"}, int'(game_state), 2);
        ticks(1, 1'b0, 1'b0, la);
        check({name, "_60_st"}, int'(game_state), 0);
    endtask

    initial begin
        int changed;

        tbl[0] = '{1'b0, 1'b1, 1,   668,  716};
        tbl[1] = '{1'b1, 1'b0, 1,   660,  708};
        tbl[2] = '{1'b1, 1'b1, 5,   660,  708};
        tbl[3] = '{1'b0, 1'b0, 3,   660,  708};
        tbl[4] = '{1'b1, 1'b0, 5,   620,  668};
        tbl[5] = '{1'b1, 1'b0, 100, 10,   58};
        tbl[6] = '{1'b0, 1'b1, 1,   18,   66};
        tbl[7] = '{1'b0, 1'b1, 200, 1309, 1357};
        tbl[8] = '{1'b1, 1'b0, 1,   1301, 1349};
        tbl[9] = '{1'b1, 1'b1, 2,   1301, 1349};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        // Paddle moves and clamps in SERVE; ball tracks it
        for (int i = 0; i < 10; i++) begin
            ticks(tbl[i].n, tbl[i].left, tbl[i].right, 1'b0);
            check($sformatf("vec%0d_px", i), int'(paddle_x), tbl[i].exp_px);
            check_ball($sformatf("vec%0d", i), tbl[i].exp_bx, 825, 0);
        end

        // No frame ticks: buttons toggle, outputs must hold
        changed = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            btn_left   = 1'($urandom);
            btn_right  = 1'($urandom);
            btn_launch = 1'($urandom);
            if (paddle_x != 11'd1301 || ball_x != 11'd1349 || ball_y != 10'd825 ||
                lives != 2'd3 || game_state != 2'd0 || miss_pulse != 1'b0)
                changed++;
        end
        check("idle_changes", changed, 0);

        // Launch from ball_x 1349: exact BX_MAX, then clamp, then reversed
        ticks(1, 1'b0, 1'b0, 1'b1);
        check_ball("launch_a", 1349, 825, 1);
        ticks(14, 1'b0, 1'b0, 1'b0);
        check_ball("at_bxmax", 1405, 769, 1);
        ticks(1, 1'b0, 1'b0, 1'b0);
        check_ball("clamp_right", 1405, 765, 1);
        ticks(1, 1'b0, 1'b0, 1'b0);
        check_ball("after_right", 1401, 761, 1);

        // Reset in the middle of play, with frame_tick high
        pulse_reset();
        check_reset_state("reset_mid_play");

        // Serve from paddle 1124 so the ball meets the left wall and the
        // paddle on the same tick after one right-wall and one top bounce
        ticks(58, 1'b0, 1'b1, 1'b0);
        check("serve_px", int'(paddle_x), 1124);
        check_ball("serve_b", 1172, 825, 0);
        ticks(1, 1'b0, 1'b0, 1'b1);
        check_ball("launch_b", 1172, 825, 1);
        ticks(58, 1'b1, 1'b0, 1'b0);
        check_ball("k58", 1404, 593, 1);
        ticks(1, 1'b1, 1'b0, 1'b0);
        check_ball("k59_right", 1405, 589, 1);
        ticks(91, 1'b1, 1'b0, 1'b0);
        check("play_px_clamp", int'(paddle_x), 10);
        ticks(54, 1'b0, 1'b0, 1'b0);
        check_ball("k204_top", 825, 11, 1);
        ticks(203, 1'b0, 1'b0, 1'b0);
        check_ball("k407", 13, 823, 1);
        ticks(1, 1'b0, 1'b0, 1'b0);
        check_ball("corner_hit", 10, 825, 1);

        // Next pass: paddle far away, ball goes past it and is missed
        ticks(408, 1'b0, 1'b0, 1'b0);
        check_ball("no_bounce", 1169, 827, 1);
        ticks(9, 1'b0, 1'b0, 1'b0);
        check_ball("pre_miss1", 1133, 863, 1);
        check("pre_miss1_pulse", int'(miss_pulse), 0);
        ticks(1, 1'b0, 1'b0, 1'b0);
        check("miss1_pulse", int'(miss_pulse), 1);
        check("miss1_lives", int'(lives), 2);
        check("miss1_st", int'(game_state), 2);
        @(negedge clk);
        check("miss1_pulse_end", int'(miss_pulse), 0);

        // Launch held through MISS re-serves on the first SERVE tick
        miss_hold("hold1", 1'b1);
        ticks(1, 1'b0, 1'b0, 1'b1);
        check_ball("relaunch1", 58, 825, 1);
        ticks(417, 1'b0, 1'b0, 1'b0);
        check("pre_miss2_st", int'(game_state), 1);
        ticks(1, 1'b0, 1'b0, 1'b0);
        check("miss2_pulse", int'(miss_pulse), 1);
        check("miss2_lives", int'(lives), 1);
        check("miss2_st", int'(game_state), 2);

        miss_hold("hold2", 1'b0);
        ticks(1, 1'b0, 1'b0, 1'b1);
        check_ball("relaunch2", 58, 825, 1);
        ticks(418, 1'b0, 1'b0, 1'b0);
        check("miss3_pulse", int'(miss_pulse), 1);
        check("miss3_lives", int'(lives), 0);
        check("miss3_st", int'(game_state), 3);

        // Game over: paddle frozen, launch restarts
        ticks(5, 1'b0, 1'b1, 1'b0);
        check("over_px", int'(paddle_x), 10);
        check("over_st", int'(game_state), 3);
        check("over_lives", int'(lives), 0);
        ticks(1, 1'b0, 1'b0, 1'b1);
        check("restart_st", int'(game_state), 0);
        check("restart_lives", int'(lives), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
